set_bit_iterator: RTL and testbench

- Downstream consumer of the team's 8-bit trailing-zero counter.
- Accepts an 8-bit word through a valid/ready handshake.
- Emits the index of every set bit, lowest first, one index per output handshake.
- Used to serialise interrupt/request vectors into a stream of bit positions for the next stage.

---
 rtl/set_bit_iterator_pkg.sv | 14 +
 rtl/set_bit_iterator_ctz8.sv | 34 +++
 rtl/set_bit_iterator.sv | 121 ++++++++++++
 tb/tb_set_bit_iterator.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/set_bit_iterator_pkg.sv
// Shared constants for the set-bit iterator: width defaults, FSM encoding and
// the "no bits set" index code.
package set_bit_iterator_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int IDX_W_DEF = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_ZERO = 2'd2;

    localparam logic [3:0] IDX_NONE = 4'd8;

endpackage

// File: rtl/set_bit_iterator_ctz8.sv
// Combinational 8-bit trailing-zero encoder; returns 0..8, with 8 for a zero
// input. Fixed priority chain so it maps onto a bounded mux tree.
module ctz8
    import set_bit_iterator_pkg::*;
(
    input  logic [7:0] din,
    output logic [3:0] cnt
);

    // Lowest set bit wins.
    always_comb begin
        cnt = IDX_NONE;
        if (din[0]) begin
            cnt = 4'd0;
        end else if (din[1]) begin
            cnt = 4'd1;
        end else if (din[2]) begin
            cnt = 4'd2;
        end else if (din[3]) begin
            cnt = 4'd3;
        end else if (din[4]) begin
            cnt = 4'd4;
        end else if (din[5]) begin
            cnt = 4'd5;
        end else if (din[6]) begin
            cnt = 4'd6;
        end else if (din[7]) begin
            cnt = 4'd7;
        end else begin
            cnt = IDX_NONE;
        end
    end

endmodule

// File: rtl/set_bit_iterator.sv
// Serialises an accepted word into a stream of set-bit indices, lowest first,
// one per output handshake; a zero word yields a single IDX_NONE beat.
module set_bit_iterator
    import set_bit_iterator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic [IDX_W-1:0] out_seq,
    output logic             busy
);

    logic [1:0]       state_r;
    logic [WIDTH-1:0] word_r;
    logic [IDX_W-1:0] seq_r;

    logic [1:0]       state_nx_s;
    logic [WIDTH-1:0] word_nx_s;
    logic [IDX_W-1:0] seq_nx_s;
    logic [WIDTH-1:0] word_dec_s;
    logic [WIDTH-1:0] word_clr_s;
    logic             one_left_s;
    logic [3:0]       ctz_s;

    ctz8 u_ctz8 (
        .din (word_r),
        .cnt (ctz_s)
    );

    // word_r is never zero in EMIT, so the decrement cannot wrap there.
    assign word_dec_s = word_r - {{(WIDTH-1){1'b0}}, 1'b1};
    assign word_clr_s = word_r & word_dec_s;
    assign one_left_s = (word_clr_s == {WIDTH{1'b0}});

    // Next-state logic for the IDLE/EMIT/ZERO sequencer.
    always_comb begin
        state_nx_s = state_r;
        word_nx_s  = word_r;
        seq_nx_s   = seq_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    word_nx_s  = in_data;
                    seq_nx_s   = {IDX_W{1'b0}};
                    state_nx_s = (in_data == {WIDTH{1'b0}}) ? ST_ZERO : ST_EMIT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    word_nx_s  = word_clr_s;
                    seq_nx_s   = seq_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    state_nx_s = one_left_s ? ST_IDLE : ST_EMIT;
                end else begin
                    state_nx_s = ST_EMIT;
                end
            end
            ST_ZERO: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_ZERO;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                word_nx_s  = {WIDTH{1'b0}};
                seq_nx_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State, word and beat-ordinal registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            word_r  <= {WIDTH{1'b0}};
            seq_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            word_r  <= word_nx_s;
            seq_r   <= seq_nx_s;
        end
    end

    // Output decode straight from registered state; no input-to-output paths.
    always_comb begin
        out_idx  = {IDX_W{1'b0}};
        out_last = 1'b0;
        case (state_r)
            ST_EMIT: begin
                out_idx  = IDX_W'(ctz_s);
                out_last = one_left_s;
            end
            ST_ZERO: begin
                out_idx  = IDX_W'(IDX_NONE);
                out_last = 1'b1;
            end
            default: begin
                out_idx  = {IDX_W{1'b0}};
                out_last = 1'b0;
            end
        endcase
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign busy      = ~in_ready;
    assign out_valid = (state_r == ST_EMIT) || (state_r == ST_ZERO);
    assign out_seq   = seq_r;

endmodule

// File: tb/tb_set_bit_iterator.sv
// Directed bench for set_bit_iterator: inputs driven and outputs checked on
// the falling edge, expected values hand-computed.
module tb_set_bit_iterator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_idx;
    logic       out_last;
    logic [3:0] out_seq;
    logic       busy;

    int total = 0;
    int bad   = 0;

    set_bit_iterator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_seq   (out_seq),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Checks one output beat at the current falling edge, then advances a cycle.
    task automatic beat(input string tag, input int idx, input int seq, input logic last);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_idx"},   32'(out_idx),   32'(idx));
        chk({tag, "_seq"},   32'(out_seq),   32'(seq));
        chk({tag, "_last"},  32'(out_last),  32'(last));
        @(negedge clk);
    endtask

    // Presents a word for one cycle; returns at the edge where the first beat shows.
    task automatic send(input string tag, input logic [7:0] d);
        chk({tag, "_inrdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hA5;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_inrdy"}, 32'(in_ready),  32'd1);
        chk({tag, "_ovld"},  32'(out_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_inrdy", 32'(in_ready),  32'd1);
        chk("rst_ovld",  32'(out_valid), 32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_idx",   32'(out_idx),   32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        chk("rst_seq",   32'(out_seq),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1011_0100 -> 2, 4, 5, 7
        send("b4", 8'hB4);
        chk("b4_busy", 32'(busy), 32'd1);
        chk("b4_inrdy0", 32'(in_ready), 32'd0);
        beat("b4_0", 2, 0, 1'b0);
        beat("b4_1", 4, 1, 1'b0);
        beat("b4_2", 5, 2, 1'b0);
        beat("b4_3", 7, 3, 1'b1);
        idle_chk("b4_end");

        // Zero word -> single IDX_NONE beat
        send("z", 8'h00);
        beat("z_0", 8, 0, 1'b1);
        idle_chk("z_end");

        // Back-to-back single-bit words
        send("h80", 8'h80);
        beat("h80_0", 7, 0, 1'b1);
        idle_chk("h80_gap");
        send("h01", 8'h01);
        beat("h01_0", 0, 0, 1'b1);
        idle_chk("h01_end");

        // Backpressure on FF
        out_ready = 1'b0;
        send("ff", 8'hFF);
        for (int i = 0; i < 3; i++) begin
            chk("ff_hold_valid", 32'(out_valid), 32'd1);
            chk("ff_hold_idx",   32'(out_idx),   32'd0);
            chk("ff_hold_seq",   32'(out_seq),   32'd0);
            chk("ff_hold_last",  32'(out_last),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            beat("ff_run", i, i, (i == 7));
        end
        idle_chk("ff_end");

        // Second word offered while busy must wait
        in_valid = 1'b1;
        in_data  = 8'h0A;
        @(negedge clk);
        in_data  = 8'h55;
        chk("hold_inrdy0", 32'(in_ready), 32'd0);
        beat("h0a_0", 1, 0, 1'b0);
        chk("hold_inrdy1", 32'(in_ready), 32'd0);
        beat("h0a_1", 3, 1, 1'b1);
        chk("h55_inrdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        beat("h55_0", 0, 0, 1'b0);
        beat("h55_1", 2, 1, 1'b0);
        beat("h55_2", 4, 2, 1'b0);
        beat("h55_3", 6, 3, 1'b1);
        idle_chk("h55_end");

        // Asynchronous reset mid-word
        send("f0", 8'hF0);
        chk("f0_idx", 32'(out_idx), 32'd4);
        chk("f0_ovld", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ovld",  32'(out_valid), 32'd0);
        chk("arst_busy",  32'(busy),      32'd0);
        chk("arst_seq",   32'(out_seq),   32'd0);
        chk("arst_last",  32'(out_last),  32'd0);
        chk("arst_inrdy", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        idle_chk("post_rst");
        send("h06", 8'h06);
        beat("h06_0", 1, 0, 1'b0);
        beat("h06_1", 2, 1, 1'b1);
        idle_chk("h06_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
